load_store_unit: RTL
====================

# load_store_unit

Parametrised memory-access pipeline stage for the RV32 core, sitting between execute (ALU result) and register write-back. It replaces the combinational, single-cycle memory access path with a valid/ready upstream handshake and a req/ack data-memory interface tolerant of wait states. It adds byte-lane enables, load extraction with sign/zero extension, misalignment and timeout faults, HALT stalling and a pipeline FLUSH.

## Interface
- XLEN, 32: data/address width of the core side; multiple of 32.
- ADDR_W, 16: data-memory byte-address width; REQ_ADDR bits above ADDR_W-1 are ignored.
- TIMEOUT, 15: maximum cycles to wait for MEM_ACK before a fault; 0 disables the timeout.
- CK_REF  in  1  clock, rising edge.
- RST_N  in  1  reset RST_N, asynchronous, active-low.
- FLUSH  in  1  synchronous pipeline flush; has priority over HALT.
- HALT  in  1  stall; freezes the stage.
- REQ_VALID  in  1  execute stage presents an op.
- REQ_READY  out  1  stage can accept an op.
- REQ_OP  in  2  00 load, 01 store, 1x non-memory passthrough.
- REQ_SIZE  in  3  000 word, 001 uhalf, 010 shalf, 011 ubyte, 100 sbyte.
- REQ_ADDR  in  XLEN  ALU result: byte address, or the passthrough value.
- REQ_WDATA  in  XLEN  rs2 value for stores.
- REQ_RD  in  5  destination register.
- REQ_WB  in  1  instruction writes rd.
- WB_VALID  out  1  one-cycle result strobe to write-back.
- WB_EN  out  1  register write enable, qualified by WB_VALID.
- WB_RD  out  5  destination register.
- WB_DATA  out  XLEN  write-back data.
- FAULT  out  1  with WB_VALID: misaligned access or timeout.
- FAULT_ADDR  out  XLEN  address of the faulting op.
- MEM_REQ  out  1  memory request, held until ack.
- MEM_WE  out  1  1 = write.
- MEM_ADDR  out  ADDR_W  byte address, low two bits forced to 0.
- MEM_BE  out  XLEN/8  byte enables.
- MEM_WDATA  out  XLEN  lane-replicated store data.
- MEM_RDATA  in  XLEN  read data; valid only with MEM_ACK.
- MEM_ACK  in  1  completes the outstanding request.

## Operation
- States: IDLE, ACCESS, RESP.
- REQ_READY = (state==IDLE) & ~HALT.
- An op is accepted at a rising edge where REQ_VALID & REQ_READY.
- Accepted passthrough: IDLE→RESP; WB_DATA = REQ_ADDR.
- Accepted aligned load or store: IDLE→ACCESS.
- Accepted misaligned op (half with addr[0]=1, or word with addr[1:0]≠0): IDLE→RESP; FAULT=1, WB_EN=0, no memory request.
- ACCESS: MEM_REQ=1 and all MEM_* outputs stable until an edge with MEM_ACK=1, then →RESP.
  - On that edge, loads capture the extracted data.
  - The ACK is honoured even while HALT is high.
- Timeout: when TIMEOUT>0 and TIMEOUT cycles elapse in ACCESS without MEM_ACK, go →RESP with FAULT=1 and WB_EN=0; MEM_REQ drops.
- RESP: WB_VALID=1. The next edge with ~HALT returns the FSM to IDLE.
- WB_EN = REQ_WB & (REQ_RD≠0) & ~FAULT & (op≠store).
- Store lanes:
  - byte: WDATA={4{b}}, BE=0001<<addr[1:0].
  - half: WDATA={2{h}}, BE=0011<<addr[1:0].
  - word: BE=1111.
- Load extraction: shift MEM_RDATA right by 8·addr[1:0], then sign-extend or zero-extend according to REQ_SIZE.
- Illegal REQ_SIZE (101–111): treated as misaligned (FAULT=1).
- HALT:
  - REQ_READY=0.
  - Timeout counter frozen.
  - All outputs held, including MEM_REQ.
- FLUSH at an edge:
  - state←IDLE, MEM_REQ←0, WB_VALID←0, counter←0.
  - An outstanding ACK arriving afterwards is ignored.
  - A flushed store may or may not have been written; upstream must not flush committed stores.
- Reset: state IDLE.
  - All registered outputs 0: MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA, WB_*, FAULT, FAULT_ADDR.
  - REQ_READY = ~HALT.

## Timing
- Passthrough: accepted at edge E0; WB_VALID during cycle E0→E1; next accept possible at E2.
- Memory op: accepted at E0; MEM_REQ high from E0. With MEM_ACK at edge E0+k (k≥1), WB_VALID is high during cycle E0+k→E0+k+1.
- Minimum load-to-writeback latency is 2 cycles.
- Maximum wait in ACCESS is TIMEOUT cycles, then a fault.
- MEM_ACK outside ACCESS is ignored.
- MEM_ACK on the same edge as the timeout expiry: the ACK wins and no fault is raised.
- FLUSH and MEM_ACK on the same edge: FLUSH wins.
- No combinational path from MEM_RDATA or MEM_ACK to any output.

## Structure
- Shared package `cpu_pkg`, or the existing defines file:
  - op encodings and size encodings,
  - `lsu_state_t` enum.
- Sub-module `lsu_lane_align`: combinational store-lane replication, BE generation, load shift and extension, misalignment detect.
- Top of the block: FSM, timeout counter, output registers.

## Test plan
- sbyte load, addr=0x0003, MEM_RDATA=0x80_00_00_00, ack on the first cycle → WB_DATA=0xFFFF_FF80, WB_EN=1, WB_VALID exactly 2 cycles after accept.
- Half store, addr=0x0002, WDATA=0x1234_ABCD, ack after 3 wait cycles → MEM_BE=1100, MEM_WDATA=0xABCD_ABCD, MEM_ADDR=0x0000, MEM_REQ held 4 cycles.
- Word load, addr=0x0006 → no MEM_REQ, WB_VALID with FAULT=1, FAULT_ADDR=0x6, WB_EN=0.
- TIMEOUT=15, ack never arrives → MEM_REQ drops after 15 cycles, FAULT=1. Second case: ack arrives on cycle 15 → no fault.
- HALT asserted in ACCESS, ack during HALT → WB_VALID withheld until HALT falls, then one pulse.
- FLUSH one cycle after a load is accepted, then a late ACK → no WB_VALID. Also check REQ_RD=0 passthrough gives WB_EN=0, and that async reset mid-ACCESS clears MEM_REQ immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the RV32 core memory pipeline: op and size codes,
// and the load/store unit state type.
package cpu_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;

    localparam logic [2:0] SIZE_WORD  = 3'b000;
    localparam logic [2:0] SIZE_UHALF = 3'b001;
    localparam logic [2:0] SIZE_SHALF = 3'b010;
    localparam logic [2:0] SIZE_UBYTE = 3'b011;
    localparam logic [2:0] SIZE_SBYTE = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_t;

    // Any op with the upper bit set bypasses memory and forwards the ALU result.
    function automatic logic is_passthrough(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: store-data replication, byte enables,
// load shift with sign/zero extension, and misalignment detection.
module lsu_lane_align
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata_lane,
    output logic [XLEN-1:0]   load_data,
    output logic              misaligned
);

    localparam int NB = XLEN / 8;

    logic [31:0] shifted;

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        be         = '0;
        wdata_lane = wdata;
        load_data  = '0;
        misaligned = 1'b0;
        shifted    = rdata[31:0] >> {addr_lo, 3'b000};
        case (size)
            SIZE_WORD: begin
                be[3:0]    = 4'b1111;
                load_data  = XLEN'($signed(shifted));
                misaligned = (addr_lo != 2'b00);
            end
            SIZE_UHALF, SIZE_SHALF: begin
                be[3:0]    = 4'b0011 << addr_lo;
                wdata_lane = {(NB/2){wdata[15:0]}};
                load_data  = (size == SIZE_SHALF) ? XLEN'($signed(shifted[15:0]))
                                                  : XLEN'(shifted[15:0]);
                misaligned = addr_lo[0];
            end
            SIZE_UBYTE, SIZE_SBYTE: begin
                be[3:0]    = 4'b0001 << addr_lo;
                wdata_lane = {NB{wdata[7:0]}};
                load_data  = (size == SIZE_SBYTE) ? XLEN'($signed(shifted[7:0]))
                                                  : XLEN'(shifted[7:0]);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access pipeline stage: valid/ready from execute, req/ack to data
// memory with wait states, timeout and misalignment faults, HALT and FLUSH.
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              CK_REF,
    input  logic              RST_N,
    input  logic              FLUSH,
    input  logic              HALT,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [1:0]        REQ_OP,
    input  logic [2:0]        REQ_SIZE,
    input  logic [XLEN-1:0]   REQ_ADDR,
    input  logic [XLEN-1:0]   REQ_WDATA,
    input  logic [4:0]        REQ_RD,
    input  logic              REQ_WB,
    output logic              WB_VALID,
    output logic              WB_EN,
    output logic [4:0]        WB_RD,
    output logic [XLEN-1:0]   WB_DATA,
    output logic              FAULT,
    output logic [XLEN-1:0]   FAULT_ADDR,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [XLEN/8-1:0] MEM_BE,
    output logic [XLEN-1:0]   MEM_WDATA,
    input  logic [XLEN-1:0]   MEM_RDATA,
    input  logic              MEM_ACK
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        lo_q, lo_d;
    logic              is_load_q, is_load_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN/8-1:0] mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_en_q, wb_en_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              fault_q, fault_d;
    logic [XLEN-1:0]   fault_addr_q, fault_addr_d;

    logic [2:0]        size_sel;
    logic [1:0]        lo_sel;
    logic [XLEN/8-1:0] lane_be;
    logic [XLEN-1:0]   lane_wdata;
    logic [XLEN-1:0]   lane_load;
    logic              lane_misaligned;
    logic              rd_writes;

    // In IDLE the lanes decode the incoming op; afterwards the captured op,
    // so load extraction uses the size/offset of the outstanding access.
    assign size_sel  = (state_q == ST_IDLE) ? REQ_SIZE : size_q;
    assign lo_sel    = (state_q == ST_IDLE) ? REQ_ADDR[1:0] : lo_q;
    assign rd_writes = REQ_WB && (REQ_RD != 5'd0);

    lsu_lane_align #(.XLEN(XLEN)) u_lane (
        .size       (size_sel),
        .addr_lo    (lo_sel),
        .wdata      (REQ_WDATA),
        .rdata      (MEM_RDATA),
        .be         (lane_be),
        .wdata_lane (lane_wdata),
        .load_data  (lane_load),
        .misaligned (lane_misaligned)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        lo_d         = lo_q;
        is_load_d    = is_load_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        wb_valid_d   = wb_valid_q;
        wb_en_d      = wb_en_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID && !HALT) begin
                    wb_rd_d      = REQ_RD;
                    fault_addr_d = REQ_ADDR;
                    size_d       = REQ_SIZE;
                    lo_d         = REQ_ADDR[1:0];
                    is_load_d    = (REQ_OP == OP_LOAD);
                    cnt_d        = '0;
                    fault_d      = 1'b0;
                    if (is_passthrough(REQ_OP)) begin
                        state_d    = ST_RESP;
                        wb_valid_d = 1'b1;
                        wb_data_d  = REQ_ADDR;
                        wb_en_d    = rd_writes;
                    end else if (lane_misaligned) begin
                        state_d    = ST_RESP;
                        wb_valid_d = 1'b1;
                        wb_data_d  = '0;
                        wb_en_d    = 1'b0;
                        fault_d    = 1'b1;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (REQ_OP == OP_STORE);
                        mem_addr_d  = {REQ_ADDR[ADDR_W-1:2], 2'b00};
                        mem_be_d    = lane_be;
                        mem_wdata_d = lane_wdata;
                        wb_en_d     = rd_writes && (REQ_OP == OP_LOAD);
                    end
                end
            end
            ST_ACCESS: begin
                // The ack completes the request even under HALT; the result
                // strobe is deferred until the stall lifts.
                if (MEM_ACK) begin
                    state_d    = ST_RESP;
                    mem_req_d  = 1'b0;
                    wb_valid_d = !HALT;
                    if (is_load_q) begin
                        wb_data_d = lane_load;
                    end
                end else if (!HALT) begin
                    if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
                        state_d    = ST_RESP;
                        mem_req_d  = 1'b0;
                        wb_valid_d = 1'b1;
                        wb_en_d    = 1'b0;
                        fault_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RESP: begin
                if (!HALT) begin
                    if (wb_valid_q) begin
                        state_d    = ST_IDLE;
                        wb_valid_d = 1'b0;
                    end else begin
                        wb_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (FLUSH) begin
            state_d    = ST_IDLE;
            mem_req_d  = 1'b0;
            wb_valid_d = 1'b0;
            cnt_d      = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            size_q       <= '0;
            lo_q         <= '0;
            is_load_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_en_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            lo_q         <= lo_d;
            is_load_q    <= is_load_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_en_q      <= wb_en_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign REQ_READY  = (state_q == ST_IDLE) && !HALT;
    assign WB_VALID   = wb_valid_q;
    assign WB_EN      = wb_en_q;
    assign WB_RD      = wb_rd_q;
    assign WB_DATA    = wb_data_q;
    assign FAULT      = fault_q;
    assign FAULT_ADDR = fault_addr_q;
    assign MEM_REQ    = mem_req_q;
    assign MEM_WE     = mem_we_q;
    assign MEM_ADDR   = mem_addr_q;
    assign MEM_BE     = mem_be_q;
    assign MEM_WDATA  = mem_wdata_q;

endmodule
